// File: rtl/onehot_enc_pkg.sv
// rtl/onehot_enc_pkg.sv - shared types, defaults and popcount for the one-hot serial encoder
package onehot_enc_pkg;

    localparam int N_IN_DEF  = 8;
    localparam int W_IDX_DEF = $clog2(N_IN_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Number of set bits in a request vector; result is wide enough to hold N_IN itself.
    function automatic logic [W_IDX_DEF:0] popcount(input logic [N_IN_DEF-1:0] v);
        logic [W_IDX_DEF:0] c;
        c = '0;
        for (int i = 0; i < N_IN_DEF; i++) begin
            c = c + {{W_IDX_DEF{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// rtl/lsb_prio_enc.sv - combinational lowest-set-bit priority encoder
module lsb_prio_enc
    import onehot_enc_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int W_IDX = W_IDX_DEF
) (
    input  logic [N_IN-1:0]  vec,
    output logic [W_IDX-1:0] idx,
    output logic             any,
    output logic             single
);

    logic [N_IN-1:0] vec_minus_one;

    assign vec_minus_one = vec - {{(N_IN-1){1'b0}}, 1'b1};
    assign any           = |vec;
    // Clearing the lowest set bit leaves nothing only when exactly one bit was set.
    assign single        = any && ((vec & vec_minus_one) == '0);

    // Scan from the top down so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[W_IDX-1:0];
            end
        end
    end

endmodule

// File: rtl/onehot_serial_encoder.sv
// rtl/onehot_serial_encoder.sv - serialises a request vector into indices of its set bits, lowest first
module onehot_serial_encoder
    import onehot_enc_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int W_IDX = W_IDX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_IDX-1:0] out_idx,
    output logic             out_last,
    output logic             zero_pulse,
    output logic [W_IDX:0]   pend_cnt
);

    state_t            state, state_n;
    logic [N_IN-1:0]   pend, pend_n;
    logic [W_IDX:0]    cnt_n;
    logic              zero_n;
    logic              ready_en;
    logic [W_IDX-1:0]  enc_idx;
    logic              enc_any;
    logic              enc_single;

    lsb_prio_enc #(
        .N_IN  (N_IN),
        .W_IDX (W_IDX)
    ) u_enc (
        .vec    (pend),
        .idx    (enc_idx),
        .any    (enc_any),
        .single (enc_single)
    );

    // Outputs come from registered state so an async reset silences them without a clock edge.
    assign in_ready  = ready_en && (state == IDLE);
    assign out_valid = (state == EMIT);
    assign out_idx   = out_valid ? enc_idx : '0;
    assign out_last  = out_valid && enc_single;

    // State, pending vector, count and pulse registers; ready_en holds in_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend       <= '0;
            pend_cnt   <= '0;
            zero_pulse <= 1'b0;
            ready_en   <= 1'b0;
        end else begin
            state      <= state_n;
            pend       <= pend_n;
            pend_cnt   <= cnt_n;
            zero_pulse <= zero_n;
            ready_en   <= 1'b1;
        end
    end

    // Next-state: capture a vector in IDLE, peel off the lowest pending bit per handshake in EMIT.
    always_comb begin
        state_n = state;
        pend_n  = pend;
        cnt_n   = pend_cnt;
        zero_n  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    pend_n = in_vec;
                    cnt_n  = popcount(in_vec);
                    if (in_vec != '0) begin
                        state_n = EMIT;
                    end else begin
                        zero_n = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready && enc_any) begin
                    pend_n = pend & (pend - {{(N_IN-1){1'b0}}, 1'b1});
                    cnt_n  = pend_cnt - {{W_IDX{1'b0}}, 1'b1};
                    if (enc_single) begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                pend_n  = '0;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_onehot_serial_encoder.sv
// tb/tb_onehot_serial_encoder.sv - directed self-checking bench for onehot_serial_encoder
module tb_onehot_serial_encoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       zero_pulse;
    logic [3:0] pend_cnt;

    int errors = 0;
    int checks = 0;

    onehot_serial_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .zero_pulse (zero_pulse),
        .pend_cnt   (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] idx,
                           input logic last, input logic [3:0] cnt);
        chk({tag, ".valid"}, 8'(out_valid), 8'(v));
        chk({tag, ".idx"},   8'(out_idx),   8'(idx));
        chk({tag, ".last"},  8'(out_last),  8'(last));
        chk({tag, ".cnt"},   8'(pend_cnt),  8'(cnt));
    endtask

    logic [2:0] exp_a5 [4];

    initial begin
        exp_a5[0] = 3'd0; exp_a5[1] = 3'd2; exp_a5[2] = 3'd5; exp_a5[3] = 3'd7;

        // Reset held with a live request on the input
        rst_n = 1'b0; in_valid = 1'b1; in_vec = 8'hA5; out_ready = 1'b1;
        #3;
        chk_out("rst", 1'b0, 3'd0, 1'b0, 4'd0);
        chk("rst.in_ready", 8'(in_ready), 8'd0);
        chk("rst.zero", 8'(zero_pulse), 8'd0);
        tick();
        chk_out("rst_edge", 1'b0, 3'd0, 1'b0, 4'd0);
        chk("rst_edge.in_ready", 8'(in_ready), 8'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        chk("rel.in_ready", 8'(in_ready), 8'd1);
        chk_out("rel", 1'b0, 3'd0, 1'b0, 4'd0);

        // 8'b1010_0101 streams 0,2,5,7 back to back
        in_valid = 1'b1; in_vec = 8'hA5;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_out($sformatf("a5[%0d]", k), 1'b1, exp_a5[k], (k == 3), 4'(4 - k));
            chk($sformatf("a5[%0d].in_ready", k), 8'(in_ready), 8'd0);
            tick();
        end
        chk_out("a5.done", 1'b0, 3'd0, 1'b0, 4'd0);
        chk("a5.in_ready", 8'(in_ready), 8'd1);

        // All-zero vector produces a single zero_pulse and no output
        in_valid = 1'b1; in_vec = 8'h00;
        tick();
        in_valid = 1'b0;
        chk("zero.pulse1", 8'(zero_pulse), 8'd1);
        chk("zero.valid1", 8'(out_valid), 8'd0);
        chk("zero.in_ready1", 8'(in_ready), 8'd1);
        tick();
        chk("zero.pulse2", 8'(zero_pulse), 8'd0);
        chk("zero.valid2", 8'(out_valid), 8'd0);

        // 8'h18 with back-pressure 0,0,1,0,1
        out_ready = 1'b0; in_valid = 1'b1; in_vec = 8'h18;
        tick();
        in_valid = 1'b0;
        chk_out("bp.c1", 1'b1, 3'd3, 1'b0, 4'd2);
        tick();
        chk_out("bp.c2", 1'b1, 3'd3, 1'b0, 4'd2);
        out_ready = 1'b1;
        tick();
        chk_out("bp.c3", 1'b1, 3'd4, 1'b1, 4'd1);
        out_ready = 1'b0;
        tick();
        chk_out("bp.c4", 1'b1, 3'd4, 1'b1, 4'd1);
        out_ready = 1'b1;
        tick();
        chk_out("bp.done", 1'b0, 3'd0, 1'b0, 4'd0);
        chk("bp.in_ready", 8'(in_ready), 8'd1);

        // 8'hFF with a second vector waiting during EMIT
        in_valid = 1'b1; in_vec = 8'hFF;
        tick();
        in_vec = 8'h01;
        for (int k = 0; k < 8; k++) begin
            chk_out($sformatf("ff[%0d]", k), 1'b1, 3'(k), (k == 7), 4'(8 - k));
            chk($sformatf("ff[%0d].in_ready", k), 8'(in_ready), 8'd0);
            tick();
        end
        chk("ff.bubble.valid", 8'(out_valid), 8'd0);
        chk("ff.bubble.in_ready", 8'(in_ready), 8'd1);
        tick();
        in_valid = 1'b0;
        chk_out("second", 1'b1, 3'd0, 1'b1, 4'd1);
        tick();
        chk_out("second.done", 1'b0, 3'd0, 1'b0, 4'd0);

        // 8'h80 is a single index that is also last
        in_valid = 1'b1; in_vec = 8'h80;
        tick();
        in_valid = 1'b0;
        chk_out("h80", 1'b1, 3'd7, 1'b1, 4'd1);
        tick();
        chk_out("h80.done", 1'b0, 3'd0, 1'b0, 4'd0);

        // Async reset in the middle of 8'hF0 after index 4 was taken
        in_valid = 1'b1; in_vec = 8'hF0;
        tick();
        in_valid = 1'b0;
        chk_out("f0[0]", 1'b1, 3'd4, 1'b0, 4'd4);
        tick();
        chk_out("f0[1]", 1'b1, 3'd5, 1'b0, 4'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 3'd0, 1'b0, 4'd0);
        chk("arst.in_ready", 8'(in_ready), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out($sformatf("post[%0d]", k), 1'b0, 3'd0, 1'b0, 4'd0);
        end
        chk("post.in_ready", 8'(in_ready), 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
